// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter:
// default sizes, FSM state encoding and a BCD digit legality helper.
package bcd_pkg;

  localparam int DEF_DIGITS = 4;
  localparam int DEF_BIN_W  = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_bcd_digit(input logic [3:0] digit);
    return digit <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction step of reverse double-dabble:
// after a right shift, a digit of 8 or more had a ten-weight carried in, so subtract 3.
module bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = (digit >= 4'd8) ? digit - 4'd3 : digit;

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one shift per clock,
// valid/ready handshake on both sides, non-decimal digits reported through err.
module bcd2bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = DEF_DIGITS,
  parameter int BIN_W  = DEF_BIN_W
) (
  input  logic                  clock,
  input  logic                  a_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [BCD_W-1:0]   bcd_work;
  logic [BIN_W-1:0]   bin_work;

  logic [BCD_W-1:0]   bcd_shift;
  logic [BCD_W-1:0]   bcd_next;
  logic [BIN_W-1:0]   bin_next;
  logic               input_bad;

  // The work register is {bcd_work, bin_work}; shifting it right moves the
  // BCD LSB into the top of the binary field.
  assign bcd_shift = bcd_work >> 1;
  assign bin_next  = {bcd_work[0], bin_work[BIN_W-1:1]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (bcd_shift[4*g +: 4]),
      .adjusted (bcd_next[4*g +: 4])
    );
  end

  // NOTE: give every always_comb output a default before any conditional
  // assignment, otherwise the tool infers a latch to hold the old value.
  always_comb begin
    input_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!is_bcd_digit(bcd_in[4*i +: 4])) input_bad = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state     <= IDLE;
      count     <= '0;
      bcd_work  <= '0;
      bin_work  <= '0;
      bin_out   <= '0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (input_bad) begin
              err       <= 1'b1;
              bin_out   <= '0;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              bcd_work <= bcd_in;
              bin_work <= '0;
              count    <= '0;
              err      <= 1'b0;
              state    <= CONV;
            end
          end
        end

        CONV: begin
          bcd_work <= bcd_next;
          bin_work <= bin_next;
          count    <= count + CNT_W'(1);
          if (count == LAST_STEP) begin
            // Every input bit has reached the binary field by now.
            assert (bcd_next == '0);
            bin_out   <= bin_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed and randomized bench for bcd2bin_seq with a scoreboard queue of
// expected results and a decimal reference model for the round trip.
module tb_bcd2bin_seq;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
  localparam int LAT    = BIN_W;

  logic              clock = 1'b0;
  logic              a_rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [15:0]       bcd_in = '0;
  logic              in_ready;
  logic              out_valid;
  logic [BIN_W-1:0]  bin_out;
  logic              err;

  typedef struct {
    logic [15:0]      bcd;
    logic [BIN_W-1:0] bin;
    logic             err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  bcd2bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clock     (clock),
    .a_rst_n   (a_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_in    (bcd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin_out   (bin_out),
    .err       (err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] b);
    exp_t e;
    int   v;
    logic [3:0] d;
    e.bcd = b;
    e.err = 1'b0;
    v = 0;
    for (int i = 3; i >= 0; i--) begin
      d = b[4*i +: 4];
      if (d > 4'd9) e.err = 1'b1;
      v = v * 10 + int'(d);
    end
    e.bin = e.err ? '0 : BIN_W'(v);
    return e;
  endfunction

  function automatic logic [15:0] to_bcd(input logic [BIN_W-1:0] v);
    logic [15:0] r;
    int x;
    x = int'(v);
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One full request/response: accept, measure latency, optional output stall, handoff.
  task automatic do_txn(input logic [15:0] b, input int stall, input bit hold_valid,
                        input bit roundtrip);
    exp_t e;
    int   n;
    logic [BIN_W-1:0] held;
    bcd_in   = b;
    in_valid = 1'b1;
    sb.push_back(model(b));
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    check("in_ready_idle", in_ready, 1'b1);
    tick();
    if (hold_valid) bcd_in = 16'hFFFF;
    else in_valid = 1'b0;
    check("in_ready_busy", in_ready, 1'b0);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    in_valid = 1'b0;
    bcd_in   = b;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check("latency", n, e.err ? 0 : LAT);
      check("bin_out", bin_out, e.bin);
      check("err", err, e.err);
      if (roundtrip && !e.err) check("roundtrip", to_bcd(bin_out), e.bcd);
    end
    held = bin_out;
    for (int i = 0; i < stall; i++) begin
      tick();
      check("stall_valid", out_valid, 1'b1);
      check("stall_bin", bin_out, held);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("handoff_valid", out_valid, 1'b0);
    check("handoff_ready", in_ready, 1'b1);
  endtask

  initial begin
    logic [15:0] rb;

    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_bin_out", bin_out, '0);
    check("rst_err", err, 1'b0);
    a_rst_n = 1'b1;
    tick();
    check("rst_in_ready", in_ready, 1'b1);

    do_txn(16'h9999, 0, 0, 1);
    do_txn(16'h0063, 0, 1, 0);
    do_txn(16'h0000, 0, 1, 0);
    do_txn(16'h12A4, 0, 0, 0);
    do_txn(16'h0126, 5, 0, 0);

    // Reset in the middle of a conversion (counter at 7).
    bcd_in   = 16'h0999;
    in_valid = 1'b1;
    sb.push_back(model(16'h0999));
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    a_rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_bin_out", bin_out, '0);
    check("midrst_err", err, 1'b0);
    void'(sb.pop_front());
    #2;
    a_rst_n = 1'b1;
    tick();
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_idle", out_valid, 1'b0);
    do_txn(16'h0050, 0, 0, 0);

    for (int k = 0; k < 1000; k++) begin
      for (int i = 0; i < 4; i++) rb[4*i +: 4] = 4'($urandom_range(0, 9));
      do_txn(rb, int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
    end

    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
